exec_unit_4x32: RTL and testbench



---
 rtl/exec_unit_4x32_if.sv | 16 +
 rtl/exec_unit_4x32.sv | 129 ++++++++++++
 tb/tb_exec_unit_4x32.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/exec_unit_4x32_if.sv
// Issue/writeback bundle between the operand read stage, the execute unit and the register file.
// The master side issues operations; the slave side (the execute unit) returns the write.
interface exec_unit_4x32_if;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  dst;
    logic        busy;
    logic [31:0] wr_data;
    logic [1:0]  dr;
    logic        write;

    modport master (output start, op, a, b, dst, input busy, wr_data, dr, write);
    modport slave  (input start, op, a, b, dst, output busy, wr_data, dr, write);
endinterface

// File: rtl/exec_unit_4x32.sv
// Execute stage for the 4x32 register file.
// Single-cycle ALU ops plus a 32-step shift-and-add multiply; all outputs are registered.
module exec_unit_4x32 (
    input  logic             clk,
    input  logic             rst,
    exec_unit_4x32_if.slave  bus
);
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_MUL  = 1'b1;
    localparam logic [2:0] OP_MUL  = 3'd7;

    logic [0:0]  state_q,   state_d;
    logic        busy_q,    busy_d;
    logic        write_q,   write_d;
    logic [31:0] wr_data_q, wr_data_d;
    logic [1:0]  dr_q,      dr_d;
    logic [1:0]  dst_q,     dst_d;
    logic [31:0] mcand_q,   mcand_d;
    logic [31:0] mplier_q,  mplier_d;
    logic [31:0] acc_q,     acc_d;
    logic [4:0]  cnt_q,     cnt_d;
    logic [31:0] acc_step_s;

    function automatic logic [31:0] alu_f(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        logic [31:0] r;
        case (op)
            3'd0:    r = a + b;
            3'd1:    r = a - b;
            3'd2:    r = a & b;
            3'd3:    r = a | b;
            3'd4:    r = a ^ b;
            3'd5:    r = a << b[4:0];
            3'd6:    r = a >> b[4:0];
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    // Accumulator value after the current multiply step (add masked by multiplier LSB).
    assign acc_step_s = acc_q + (mcand_q & {32{mplier_q[0]}});

    // Next-state logic for the issue/multiply sequencer.
    always_comb begin
        state_d   = state_q;
        busy_d    = busy_q;
        write_d   = 1'b0;
        wr_data_d = wr_data_q;
        dr_d      = dr_q;
        dst_d     = dst_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    if (bus.op != OP_MUL) begin
                        wr_data_d = alu_f(bus.op, bus.a, bus.b);
                        dr_d      = bus.dst;
                        write_d   = 1'b1;
                    end else begin
                        mcand_d  = bus.a;
                        mplier_d = bus.b;
                        acc_d    = 32'd0;
                        cnt_d    = 5'd0;
                        dst_d    = bus.dst;
                        busy_d   = 1'b1;
                        state_d  = ST_MUL;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_MUL: begin
                acc_d    = acc_step_s;
                mcand_d  = {mcand_q[30:0], 1'b0};
                mplier_d = {1'b0, mplier_q[31:1]};
                cnt_d    = cnt_q + 5'd1;
                // Step with counter 31 is the last; the write fires in the following cycle.
                if (cnt_q == 5'd31) begin
                    wr_data_d = acc_step_s;
                    dr_d      = dst_q;
                    write_d   = 1'b1;
                    busy_d    = 1'b0;
                    state_d   = ST_IDLE;
                end else begin
                    state_d = ST_MUL;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            busy_q    <= 1'b0;
            write_q   <= 1'b0;
            wr_data_q <= 32'd0;
            dr_q      <= 2'd0;
            dst_q     <= 2'd0;
            mcand_q   <= 32'd0;
            mplier_q  <= 32'd0;
            acc_q     <= 32'd0;
            cnt_q     <= 5'd0;
        end else begin
            state_q   <= state_d;
            busy_q    <= busy_d;
            write_q   <= write_d;
            wr_data_q <= wr_data_d;
            dr_q      <= dr_d;
            dst_q     <= dst_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
        end
    end

    assign bus.busy    = busy_q;
    assign bus.write   = write_q;
    assign bus.wr_data = wr_data_q;
    assign bus.dr      = dr_q;
endmodule

// File: tb/tb_exec_unit_4x32.sv
// Directed scoreboard bench for exec_unit_4x32: expected writes are queued at issue time
// and compared, including their arrival cycle, whenever the unit raises write.
module tb_exec_unit_4x32;
    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  dr;
        int          cyc;
    } exp_t;
    exp_t sb[$];

    exec_unit_4x32_if bus ();

    exec_unit_4x32 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // Free-running cycle count used to time-stamp expected writes.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        logic [63:0] p;
        int          sh;
        sh = int'(b % 32);
        case (op)
            3'd0: return a + b;
            3'd1: return a + ~b + 32'd1;
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: return a ^ b;
            3'd5: return a << sh;
            3'd6: return a >> sh;
            default: begin
                p = {32'd0, a} * {32'd0, b};
                return p[31:0];
            end
        endcase
    endfunction

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] dst, input bit expect_wr, input logic [31:0] res);
        exp_t e;
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        bus.dst   = dst;
        if (expect_wr) begin
            e.data = res;
            e.dr   = dst;
            e.cyc  = cyc + ((op == 3'd7) ? 33 : 1);
            sb.push_back(e);
        end
    endtask

    task automatic idle();
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    initial begin
        int          n;
        logic [2:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;
        exp_t        e;

        rst       = 1'b1;
        bus.start = 1'b0;
        bus.op    = 3'd0;
        bus.a     = 32'd0;
        bus.b     = 32'd0;
        bus.dst   = 2'd0;

        // Writeback monitor: every write must match the head of the scoreboard in data, index and cycle.
        fork
            begin
                exp_t m;
                forever begin
                    @(negedge clk);
                    if (bus.write === 1'b1) begin
                        if (sb.size() == 0) begin
                            check("unexpected_write", {31'd0, bus.write}, 32'd0);
                        end else begin
                            m = sb.pop_front();
                            check("wr_data", bus.wr_data, m.data);
                            check("dr", {30'd0, bus.dr}, {30'd0, m.dr});
                            check("write_cycle", cyc, m.cyc);
                        end
                    end else if (sb.size() != 0 && cyc >= sb[0].cyc) begin
                        check("missing_write_cycle", cyc, sb[0].cyc - 1);
                        void'(sb.pop_front());
                    end
                end
            end
        join_none

        repeat (2) @(negedge clk);
        check("reset_busy", {31'd0, bus.busy}, 32'd0);
        check("reset_write", {31'd0, bus.write}, 32'd0);
        check("reset_wr_data", bus.wr_data, 32'd0);
        check("reset_dr", {30'd0, bus.dr}, 32'd0);
        rst = 1'b0;

        issue(3'd0, 32'h0000_0005, 32'h0000_0007, 2'd2, 1'b1, 32'h0000_000C);
        idle();
        check("alu_busy_low", {31'd0, bus.busy}, 32'd0);
        @(negedge clk);

        issue(3'd1, 32'h0000_0005, 32'h0000_0007, 2'd1, 1'b1, 32'hFFFF_FFFE);
        issue(3'd5, 32'h0000_0001, 32'd33,        2'd0, 1'b1, 32'h0000_0002);
        issue(3'd6, 32'h8000_0000, 32'd31,        2'd3, 1'b1, 32'h0000_0001);
        idle();
        @(negedge clk);

        issue(3'd7, 32'd7, 32'd6, 2'd3, 1'b1, 32'h0000_002A);
        idle();
        n = int'(bus.busy);
        repeat (39) begin
            @(negedge clk);
            n += int'(bus.busy);
        end
        check("mul_busy_cycles", n, 32'd32);

        issue(3'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'd1, 1'b1, 32'h0000_0001);
        idle();
        repeat (34) @(negedge clk);

        // Start held high with an ADD across a whole multiply.
        issue(3'd7, 32'h1234_5678, 32'h9ABC_DEF1, 2'd2, 1'b1,
              model(3'd7, 32'h1234_5678, 32'h9ABC_DEF1));
        @(negedge clk);
        bus.op  = 3'd0;
        bus.a   = 32'd100;
        bus.b   = 32'd23;
        bus.dst = 2'd1;
        e.data  = 32'd123;
        e.dr    = 2'd1;
        e.cyc   = cyc + 33;
        sb.push_back(e);
        repeat (32) @(negedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            rop = 3'($urandom_range(0, 6));
            ra  = $urandom;
            rb  = $urandom;
            issue(rop, ra, rb, 2'(i), 1'b1, model(rop, ra, rb));
        end
        idle();
        ra = $urandom;
        rb = $urandom;
        issue(3'd7, ra, rb, 2'd2, 1'b1, model(3'd7, ra, rb));
        idle();
        repeat (34) @(negedge clk);

        // Reset lands on multiply step 10: the multiply is abandoned with no write.
        issue(3'd7, 32'd3, 32'd5, 2'd2, 1'b0, 32'd0);
        idle();
        repeat (8) @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy", {31'd0, bus.busy}, 32'd0);
        check("abort_write", {31'd0, bus.write}, 32'd0);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        check("abort_wr_data", bus.wr_data, 32'd0);
        check("abort_dr", {30'd0, bus.dr}, 32'd0);

        // Prime nonzero outputs, then collide reset with an ADD issue.
        issue(3'd3, 32'h00F0_0000, 32'h0000_000F, 2'd3, 1'b1, 32'h00F0_000F);
        idle();
        @(negedge clk);
        rst       = 1'b1;
        bus.start = 1'b1;
        bus.op    = 3'd0;
        bus.a     = 32'd5;
        bus.b     = 32'd7;
        bus.dst   = 2'd3;
        @(negedge clk);
        check("rst_start_write", {31'd0, bus.write}, 32'd0);
        check("rst_start_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_start_wr_data", bus.wr_data, 32'd0);
        check("rst_start_dr", {30'd0, bus.dr}, 32'd0);
        rst       = 1'b0;
        bus.start = 1'b0;
        repeat (3) @(negedge clk);

        issue(3'd4, 32'hA5A5_A5A5, 32'hFFFF_0000, 2'd1, 1'b1, 32'h5A5A_A5A5);
        idle();

        for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk);
        check("scoreboard_empty", sb.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
